// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: access-size codes from the decoder, opcodes and
// the MEM-stage access FSM state type.
package rv32i_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Size code 2'b11 falls into the word rule.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: is_aligned = 1'b1;
      SIZE_HALF: is_aligned = ~lo[0];
      default:   is_aligned = (lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane logic for the data-memory port: store byte enables and lane
// replication on the request side, load extraction and extension on the response side.
module mem_lane_unit
  import rv32i_pkg::*;
(
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_lo,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  output logic [31:0] req_lane_wdata,
  input  logic [1:0]  rsp_size,
  input  logic [1:0]  rsp_lo,
  input  logic        rsp_unsigned,
  input  logic [31:0] rsp_word,
  output logic [31:0] rsp_data
);

  logic [31:0] shifted;

  always_comb begin
    req_be         = 4'b1111;
    req_lane_wdata = req_wdata;
    case (req_size)
      SIZE_BYTE: begin
        req_be         = 4'b0001 << req_lo;
        req_lane_wdata = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        req_be         = 4'b0011 << req_lo;
        req_lane_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
    // Reads drive a quiet data bus.
    if (!req_write) req_lane_wdata = '0;
  end

  assign shifted = rsp_word >> {rsp_lo, 3'b000};

  always_comb begin
    rsp_data = shifted;
    case (rsp_size)
      SIZE_BYTE: rsp_data = rsp_unsigned ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: rsp_data = rsp_unsigned ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer onto a word-wide data bus.
// Bus handshake: dmem_req is held high with all dmem_* fields stable until the
// one-cycle dmem_ack (dmem_rdata valid with it); ack outside a request is ignored.
module mem_access_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  inst_size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  dbg_state
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  mem_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic        stall_c;

  logic        access, illegal;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;

  assign access  = mem_read | mem_write;
  assign illegal = (mem_read & mem_write) | ~is_aligned(inst_size, addr[1:0]);

  mem_lane_unit u_lane (
    .req_size       (inst_size),
    .req_lo         (addr[1:0]),
    .req_write      (mem_write),
    .req_wdata      (wdata),
    .req_be         (lane_be),
    .req_lane_wdata (lane_wdata),
    .rsp_size       (size_q),
    .rsp_lo         (lo_q),
    .rsp_unsigned   (uns_q),
    .rsp_word       (dmem_rdata),
    .rsp_data       (lane_rdata)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    we_d          = we_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    size_d        = size_q;
    uns_d         = uns_q;
    lo_d          = lo_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    misalign_d    = 1'b0;
    bus_err_d     = 1'b0;
    stall_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (access) begin
          if (illegal) begin
            misalign_d = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = ST_REQ;
            addr_d  = {addr[31:2], 2'b00};
            we_d    = mem_write;
            be_d    = lane_be;
            wdata_d = lane_wdata;
            size_d  = inst_size;
            uns_d   = load_unsigned;
            lo_d    = addr[1:0];
          end
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        // An ack in the expiry cycle still completes the access normally.
        if (dmem_ack) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          if (!we_q) begin
            rdata_d       = lane_rdata;
            rdata_valid_d = 1'b1;
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d   = ST_DONE;
          cnt_d     = '0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        // The completed instruction is still in MEM this cycle; ignore it.
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      be_q          <= '0;
      wdata_q       <= '0;
      size_q        <= SIZE_WORD;
      uns_q         <= 1'b0;
      lo_q          <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      lo_q          <= lo_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      misalign_q    <= misalign_d;
      bus_err_q     <= bus_err_d;
    end
  end

  // Masking with reset_n keeps stall low while reset is held, even if MEM still shows an access.
  assign stall        = stall_c & reset_n;
  assign dmem_req     = (state_q == ST_REQ);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign rdata        = rdata_q;
  assign rdata_valid  = rdata_valid_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stimulus pushes expected bus beats and
// responses into a queue; a negedge monitor pops and compares them.
module tb_mem_access_ctrl;
  import rv32i_pkg::*;

  localparam int W = 72;
  localparam logic [3:0] K_RD    = 4'd1;
  localparam logic [3:0] K_WR    = 4'd2;
  localparam logic [3:0] K_RDATA = 4'd3;
  localparam logic [3:0] K_MIS   = 4'd4;
  localparam logic [3:0] K_BUS   = 4'd5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, load_unsigned = 1'b0;
  logic [1:0]  inst_size = SIZE_WORD;
  logic [31:0] addr = '0, wdata = '0, dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        stall, rdata_valid, misalign_err, bus_err, dmem_req, dmem_we;
  logic [31:0] rdata, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  last_rdata = '0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .inst_size(inst_size), .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .misalign_err(misalign_err),
    .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] k, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] d);
    exp_q.push_back({k, be, a, d});
  endtask

  task automatic observe(input logic [W-1:0] got);
    logic [W-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_unexpected: got %h expected no event", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_errors++;
        $display("FAIL sb_event: got %h expected %h", got, e);
      end
    end
  endtask

  // Monitor: every bus completion and every response pulse is one event.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (dmem_req && dmem_ack)
          observe({dmem_we ? K_WR : K_RD, dmem_be, dmem_addr, dmem_wdata});
        if (rdata_valid)  observe({K_RDATA, 4'h0, 32'h0, rdata});
        if (misalign_err) observe({K_MIS, 4'h0, 32'h0, 32'h0});
        if (bus_err)      observe({K_BUS, 4'h0, 32'h0, 32'h0});
      end
    end
  end

  // Drives one MEM-stage access and acts as the bus slave until stall drops.
  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rw, input int waits,
                        input bit give_ack, input logic [31:0] e_addr,
                        input logic [3:0] e_be, input logic [31:0] e_wdata,
                        output int stalls, output int reqs);
    int guard;
    bit fin;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; inst_size = sz; load_unsigned = uns;
    addr = a; wdata = wd; dmem_rdata = rw; dmem_ack = 1'b0;
    stalls = 0; reqs = 0; guard = 0; fin = 0;
    while (!fin) begin
      @(negedge clk);
      if (stall) stalls++;
      if (dmem_req) begin
        reqs++;
        chk({name, "_addr"}, dmem_addr, e_addr);
        chk({name, "_be"}, {28'h0, dmem_be}, {28'h0, e_be});
        chk({name, "_wdata"}, dmem_wdata, e_wdata);
        chk({name, "_we"}, {31'h0, dmem_we}, {31'h0, wr});
      end
      if (!stall) begin
        fin = 1;
      end else if (++guard > 40) begin
        n_checks++; n_errors++;
        $display("FAIL %s_bound: got stall after %0d cycles expected release", name, guard);
        fin = 1;
      end else begin
        @(posedge clk); #1;
        dmem_ack = give_ack && dmem_req && (reqs == waits);
      end
    end
  endtask

  task automatic do_load(input string name, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] rw, input int waits,
                         input logic [3:0] e_be, input logic [31:0] e_rdata);
    int st, rq;
    push(K_RD, e_be, {a[31:2], 2'b00}, 32'h0);
    push(K_RDATA, 4'h0, 32'h0, e_rdata);
    access(name, 1'b1, 1'b0, sz, uns, a, 32'h0, rw, waits, 1'b1, {a[31:2], 2'b00}, e_be,
           32'h0, st, rq);
    chk({name, "_stalls"}, st, waits + 2);
    chk({name, "_reqs"}, rq, waits + 1);
    last_rdata = e_rdata;
  endtask

  task automatic do_store(input string name, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int waits, input logic [3:0] e_be,
                          input logic [31:0] e_wdata);
    int st, rq;
    push(K_WR, e_be, {a[31:2], 2'b00}, e_wdata);
    access(name, 1'b0, 1'b1, sz, 1'b0, a, wd, 32'h0, waits, 1'b1, {a[31:2], 2'b00}, e_be,
           e_wdata, st, rq);
    chk({name, "_stalls"}, st, waits + 2);
    chk({name, "_reqs"}, rq, waits + 1);
  endtask

  task automatic do_illegal(input string name, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic [31:0] a);
    int st, rq;
    push(K_MIS, 4'h0, 32'h0, 32'h0);
    access(name, rd, wr, sz, 1'b0, a, 32'h5555AAAA, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0,
           st, rq);
    chk({name, "_stalls"}, st, 0);
    chk({name, "_reqs"}, rq, 0);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk({name, "_req_after"}, {31'h0, dmem_req}, 32'h0);
    chk({name, "_stall_after"}, {31'h0, stall}, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b0;
    end
  endtask

  initial begin
    int st, rq;
    // Reset values while reset is held
    repeat (2) @(negedge clk);
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_be", {28'h0, dmem_be}, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_pulses", {29'h0, rdata_valid, misalign_err, bus_err}, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, 32'(ST_IDLE));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Back-to-back loads and stores
    do_load("lw_100", SIZE_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF);
    do_load("lb_103", SIZE_BYTE, 1'b0, 32'h103, 32'h80000000, 0, 4'b1000, 32'hFFFFFF80);
    do_load("lbu_103", SIZE_BYTE, 1'b1, 32'h103, 32'h80000000, 0, 4'b1000, 32'h00000080);
    do_load("lh_102", SIZE_HALF, 1'b0, 32'h102, 32'h80017777, 0, 4'b1100, 32'hFFFF8001);
    do_load("lhu_100", SIZE_HALF, 1'b1, 32'h100, 32'h1234F00F, 0, 4'b0011, 32'h0000F00F);
    do_load("lw_sz3", 2'b11, 1'b0, 32'h104, 32'h76543210, 1, 4'b1111, 32'h76543210);
    do_store("sh_202", SIZE_HALF, 32'h202, 32'h1234ABCD, 3, 4'b1100, 32'hABCDABCD);
    do_store("sb_201", SIZE_BYTE, 32'h201, 32'h0000005A, 0, 4'b0010, 32'h5A5A5A5A);
    do_store("sw_300", SIZE_WORD, 32'h300, 32'hCAFEF00D, 1, 4'b1111, 32'hCAFEF00D);
    idle(2);

    // Illegal accesses
    do_illegal("mis_lw_101", 1'b1, 1'b0, SIZE_WORD, 32'h101);
    do_illegal("mis_rdwr", 1'b1, 1'b1, SIZE_WORD, 32'h100);
    do_illegal("mis_lh_103", 1'b1, 1'b0, SIZE_HALF, 32'h103);

    // Timeout: four REQ cycles, bus_err, rdata untouched
    push(K_BUS, 4'h0, 32'h0, 32'h0);
    access("to_lw", 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h400, 32'h0, 32'h11111111, 0, 1'b0,
           32'h400, 4'b1111, 32'h0, st, rq);
    chk("to_reqs", rq, 4);
    chk("to_stalls", st, 5);
    chk("to_rdata_held", rdata, last_rdata);
    idle(1);

    // Ack in the expiry cycle wins
    do_load("ack_at_expiry", SIZE_WORD, 1'b0, 32'h500, 32'h0BADF00D, 3, 4'b1111, 32'h0BADF00D);
    idle(1);

    // Stray ack while idle
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("stray_ack_req", {31'h0, dmem_req}, 32'h0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_state", {30'h0, dbg_state}, 32'(ST_IDLE));
    chk("stray_ack_valid", {31'h0, rdata_valid}, 32'h0);

    // Asynchronous reset during REQ
    @(posedge clk); #1;
    mem_read = 1'b1; inst_size = SIZE_WORD; addr = 32'h600;
    @(posedge clk); #1;
    chk("rstreq_pre_req", {31'h0, dmem_req}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstreq_req", {31'h0, dmem_req}, 32'h0);
    chk("rstreq_stall", {31'h0, stall}, 32'h0);
    chk("rstreq_state", {30'h0, dbg_state}, 32'(ST_IDLE));
    chk("rstreq_rdata", rdata, 32'h0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_load("post_rst_lw", SIZE_WORD, 1'b0, 32'h604, 32'h13572468, 0, 4'b1111, 32'h13572468);

    idle(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got %0d pending events expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences every load/store from the MEM stage of the RV32I core onto a word-wide data-memory bus with a req/ack handshake. Driven by the decoder's mem_read, mem_write and inst_size controls. Generates byte enables and lane-replicated write data, extracts and sign/zero-extends load data, and stalls the pipeline until the access completes. Also flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in REQ without dmem_ack before bus_err; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
mem_read  in  1  load in MEM stage
mem_write  in  1  store in MEM stage
inst_size  in  2  00 word, 01 half, 10 byte; 11 treated as word
load_unsigned  in  1  funct3[2]; 1 means lbu/lhu
addr  in  32  byte address from ALU
wdata  in  32  store data (rs2)
stall  out  1  hold PC and pipeline registers
rdata  out  32  extended load result
rdata_valid  out  1  one-cycle pulse; rdata is valid
misalign_err  out  1  one-cycle pulse; misaligned access, or read and write both set
bus_err  out  1  one-cycle pulse; timeout expired
dmem_req  out  1  bus request
dmem_we  out  1  1 write, 0 read
dmem_addr  out  32  {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated write data
dmem_ack  in  1  bus completion, 1 cycle
dmem_rdata  in  32  read word, valid with dmem_ack

Behaviour:
- Reset (async, any state): state=IDLE. dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, rdata, rdata_valid, misalign_err, bus_err and the timeout counter all go to 0. Any in-flight bus request is abandoned.
- FSM states: IDLE, REQ, DONE.
- IDLE, access present (mem_read|mem_write):
  - Aligned means word: addr[1:0]==0; half: addr[0]==0; byte: always.
  - Illegal if mem_read&mem_write, or if misaligned.
  - Illegal: misalign_err=1 next cycle, no bus request, stall stays 0, remain IDLE.
  - Legal: stall=1 combinationally in the same cycle. Register dmem_addr, dmem_we, dmem_be, dmem_wdata, size and unsigned flag. Go to REQ; dmem_req=1 from the next cycle.
- Byte enables and write data:
  - byte: be = 4'b0001<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: be = 4'b0011<<addr[1:0]; wdata = {2{wdata[15:0]}}.
  - word: be = 4'b1111; wdata unchanged.
  - Reads drive the same be pattern. dmem_wdata on reads: don't-care, driven 0.
- REQ:
  - stall=1; dmem_req=1; all dmem_* outputs held stable.
  - The timeout counter increments each REQ cycle.
  - On dmem_ack, read: rdata = (dmem_rdata >> 8*addr[1:0]) truncated to size, then sign-extended (load_unsigned=0) or zero-extended (load_unsigned=1); word is passed through. Go to DONE.
  - On dmem_ack, write: go to DONE.
  - Timeout: counter reaches TIMEOUT_CYCLES with no ack → dmem_req=0, bus_err=1 for one cycle, go to DONE. rdata is not updated and rdata_valid stays 0.
  - An ack in the same cycle as timeout expiry wins (normal completion).
- DONE:
  - stall=0, dmem_req=0, counter cleared. rdata_valid=1 only after a successful read.
  - MEM-stage inputs still show the completed instruction this cycle, so they are ignored. Next state is IDLE.
- Latency: ack in the first REQ cycle gives 2 stall cycles (detect, REQ), then DONE. Each extra wait cycle adds one stall cycle.
- Back-to-back accesses: each is a separate IDLE→REQ→DONE pass. DONE→IDLE costs no extra cycle, because the next instruction is seen in IDLE on the cycle after DONE.
- dmem_ack outside REQ is ignored.
- rdata holds its value until the next successful read.

Decomposition:
- Shared package rv32i_pkg: size encodings WORD/HALF/BYTE (the same 2-bit codes the decoder emits), opcode constants, and the FSM state typedef.
- One sub-module, mem_lane_unit (combinational): be/wdata generation and load extraction/extension. The FSM, counter and registers stay in mem_access_ctrl.

Test Plan:
- lw, addr=0x100, ack on first REQ cycle with dmem_rdata=0xDEADBEEF → dmem_addr=0x100, be=1111, stall high 2 cycles, rdata=0xDEADBEEF with rdata_valid in DONE.
- lb, addr=0x103, dmem_rdata=0x80_00_00_00 → be=1000, rdata=0xFFFFFF80; the same access as lbu gives rdata=0x00000080.
- sh, addr=0x202, wdata=0x1234ABCD, ack after 3 wait cycles → dmem_we=1, be=1100, dmem_wdata=0xABCDABCD held stable throughout, stall high 5 cycles.
- lw at addr=0x101 → misalign_err pulse, dmem_req never asserted, stall stays 0. Also drive mem_read and mem_write together → misalign_err.
- TIMEOUT_CYCLES=4, no ack → dmem_req drops after 4 REQ cycles, bus_err pulse, stall released, rdata_valid=0.
- reset_n low while in REQ → dmem_req and stall drop to 0 immediately (asynchronously). After release, the FSM is in IDLE and a new lw completes normally.
